// File: rtl/sha256_compress_core.sv
// Iterative SHA-256 compression: one round per clock, chained digest out after the last round.
// Optional abort input enabled by defining SHA256_ABORT_EN.
module sha256_compress_core #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] h_in,
  input  logic         w_valid,
  output logic         w_ready,
  input  logic [31:0]  w_data,
  output logic         busy,
  output logic         digest_valid,
  output logic [255:0] digest
`ifdef SHA256_ABORT_EN
  ,
  input  logic         abort
`endif
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  localparam logic [5:0] TLAST = 6'(ROUNDS - 1);

  localparam logic [31:0] KROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_t           state_q, state_d;
  logic [5:0]       t_q;
  logic [7:0][31:0] wv_q, hr_q, wv_nxt, dsum;
  logic             abort_w, hs, last;

`ifdef SHA256_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Working variables packed a..h from high lane to low lane, matching h_in/digest order.
  logic [31:0] a, b, c, d, e, f, g, h;
  assign {a, b, c, d, e, f, g, h} = wv_q;

  logic [31:0] s0, s1, ch, maj, t1, t2;
  assign s1  = {e[5:0], e[31:6]} ^ {e[10:0], e[31:11]} ^ {e[24:0], e[31:25]};
  assign s0  = {a[1:0], a[31:2]} ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]};
  assign ch  = (e & f) ^ (~e & g);
  assign maj = (a & b) ^ (a & c) ^ (b & c);
  assign t1  = h + s1 + ch + KROM[t_q] + w_data;
  assign t2  = s0 + maj;
  assign wv_nxt = {t1 + t2, a, b, c, d + t1, e, f, g};

  for (genvar i = 0; i < 8; i++) begin : g_fold
    assign dsum[i] = hr_q[i] + wv_q[i];
  end

  assign last = (t_q == TLAST);
  assign hs   = w_valid && (state_q == ROUND) && !abort_w;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    w_ready = 1'b0;
    busy    = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = ROUND;
      ROUND: begin
        w_ready = 1'b1;
        busy    = 1'b1;
        if (abort_w)          state_d = IDLE;
        else if (hs && last)  state_d = FINAL;
      end
      FINAL: begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wv_q         <= '0;
      hr_q         <= '0;
      t_q          <= '0;
      digest       <= '0;
      digest_valid <= 1'b0;
    end else begin
      digest_valid <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          hr_q <= h_in;
          wv_q <= h_in;
          t_q  <= '0;
        end
        ROUND: begin
          if (abort_w) t_q <= '0;
          else if (hs) begin
            wv_q <= wv_nxt;
            // Hold t on the final round so the counter never wraps.
            if (!last) t_q <= t_q + 6'd1;
          end
        end
        FINAL: begin
          t_q <= '0;
          if (!abort_w) begin
            digest       <= dsum;
            digest_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
